// File: rtl/dig_pkg.sv
// Shared types and defaults for the digital PWM output stage.
package dig_pkg;

  localparam int DIG_WIDTH = 8;

  typedef enum logic {DISABLED, RUN} pwm_state_t;

  typedef logic [DIG_WIDTH-1:0] dig_word_t;

endpackage

// File: rtl/dig_avg.sv
// Block averager: sums 2**AVG_LOG2 period samples and emits their truncated mean.
module dig_avg
  import dig_pkg::*;
#(
  parameter int WIDTH    = DIG_WIDTH,
  parameter int AVG_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  output logic [WIDTH-1:0] avg,
  output logic             avg_done
);

  localparam int SW = WIDTH + AVG_LOG2;
  // one bit of sample counter still exists in pass-through mode; it simply never moves
  localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [NW-1:0] LAST = NW'((1 << AVG_LOG2) - 1);

  logic [SW-1:0] acc_r;
  logic [NW-1:0] nsamp_r;
  logic [SW-1:0] sum_s;

  assign sum_s    = acc_r + SW'(sample_in);
  assign avg      = WIDTH'(sum_s >> AVG_LOG2);
  assign avg_done = sample_valid && (nsamp_r == LAST);

  // accumulate samples, restarting the block once the last one arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r   <= {SW{1'b0}};
      nsamp_r <= {NW{1'b0}};
    end else if (sample_valid) begin
      if (nsamp_r == LAST) begin
        acc_r   <= {SW{1'b0}};
        nsamp_r <= {NW{1'b0}};
      end else begin
        acc_r   <= sum_s;
        nsamp_r <= nsamp_r + NW'(1);
      end
    end
  end

endmodule

// File: rtl/dig_pwm.sv
// Free-running PWM whose duty tracks the averaged trigger period; duty only
// changes at frame boundaries so the analog side never sees a mid-frame glitch.
module dig_pwm
  import dig_pkg::*;
#(
  parameter int WIDTH    = DIG_WIDTH,
  parameter int AVG_LOG2 = 2,
  parameter bit INVERT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             sample_valid,
  input  logic             enable,
  output logic             pwm_out,
  output logic [WIDTH-1:0] duty_out,
  output logic             frame_start
);

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

  pwm_state_t       state_r;
  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] duty_active_r;
  logic [WIDTH-1:0] duty_pending_r;
  logic             pending_r;
  logic             pwm_out_r;
  logic             frame_start_r;
  logic [WIDTH-1:0] avg_s;
  logic             avg_done_s;
  logic             load_s;

  dig_avg #(
    .WIDTH    (WIDTH),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .avg          (avg_s),
    .avg_done     (avg_done_s)
  );

  // while idle the duty loads at once; while running only in the last frame cycle
  assign load_s = (state_r == DISABLED) || (cnt_r == CNT_MAX);

  // FSM, frame counter, duty hand-over and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= DISABLED;
      cnt_r          <= {WIDTH{1'b0}};
      duty_active_r  <= {WIDTH{1'b0}};
      duty_pending_r <= {WIDTH{1'b0}};
      pending_r      <= 1'b0;
      pwm_out_r      <= INVERT;
      frame_start_r  <= 1'b0;
    end else begin
      if (avg_done_s) begin
        duty_pending_r <= avg_s;
      end
      // a fresh average in the load cycle bypasses the pending register
      if (load_s) begin
        if (avg_done_s) begin
          duty_active_r <= avg_s;
        end else if (pending_r) begin
          duty_active_r <= duty_pending_r;
        end
        pending_r <= 1'b0;
      end else if (avg_done_s) begin
        pending_r <= 1'b1;
      end

      case (state_r)
        DISABLED: begin
          cnt_r <= {WIDTH{1'b0}};
          if (enable) begin
            state_r <= RUN;
          end
        end
        RUN: begin
          if (!enable) begin
            state_r <= DISABLED;
            cnt_r   <= {WIDTH{1'b0}};
          end else begin
            cnt_r <= cnt_r + WIDTH'(1);
          end
        end
        default: begin
          state_r <= DISABLED;
          cnt_r   <= {WIDTH{1'b0}};
        end
      endcase

      pwm_out_r     <= INVERT ^ ((state_r == RUN) && enable && (cnt_r < duty_active_r));
      frame_start_r <= (state_r == RUN) && (cnt_r == {WIDTH{1'b0}});
    end
  end

  assign pwm_out     = pwm_out_r;
  assign frame_start = frame_start_r;
  assign duty_out    = duty_active_r;

endmodule
